// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   Slave-side memory model for the cache refill/writeback bus. It answers
//   the cache's read and write requests from an internal word-addressed RAM.
//   Reads return either a 4-beat line or a single word. The first beat
//   arrives RD_LAT cycles after the handshake, and the beats follow on
//   consecutive cycles with no backpressure. Writes store a whole line or
//   one byte-merged word at the handshake edge. A line write then keeps the
//   write engine busy for WR_LINE_CYC-1 cycles.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   rd_req/rd_type/rd_addr       read request (type 3'b100 = 16B line)
//   rd_rdy                       read request accepted when high with rd_req
//   ret_valid/ret_last/ret_data  return beats (ret_last[0] marks the last)
//   wr_req/wr_type/wr_addr       write request (type 3'b100 = 16B line)
//   wr_wstrb/wr_data             byte enables (single only) and line data
//   wr_rdy                       write engine idle
module cache_mem_responder #(
    parameter int MEM_AW      = 10,
    parameter int RD_LAT      = 2,
    parameter int WR_LINE_CYC = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [1:0]   ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam int DEPTH = 1 << MEM_AW;
    // Wait-state count loaded at the handshake. R_WAIT lasts LAT_INIT+1 cycles.
    localparam logic [3:0] LAT_INIT   = (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;
    localparam logic [1:0] WBUSY_INIT = (WR_LINE_CYC >= 2) ? 2'(WR_LINE_CYC - 2) : 2'd0;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BEAT = 2'd2} rd_state_t;
    typedef enum logic {W_IDLE = 1'b0, W_BUSY = 1'b1} wr_state_t;

    logic [31:0] mem [DEPTH];

    rd_state_t         rd_state, rd_state_nxt;
    logic [3:0]        lat_cnt, lat_cnt_nxt;
    logic [1:0]        beat, beat_nxt;
    logic [MEM_AW-1:0] rd_base, rd_base_nxt;
    logic [1:0]        rd_last, rd_last_nxt;

    wr_state_t         wr_state, wr_state_nxt;
    logic [1:0]        wr_cnt, wr_cnt_nxt;

    logic [MEM_AW-1:0] rd_idx, wr_idx, beat_idx;
    logic [MEM_AW-3:0] wr_line_idx;
    logic              rd_line, wr_line, rd_fire, wr_fire;
    logic              unused_addr_bits;

    // Upper address bits alias and byte offsets are ignored.
    assign rd_idx      = rd_addr[MEM_AW+1:2];
    assign wr_idx      = wr_addr[MEM_AW+1:2];
    assign wr_line_idx = wr_idx[MEM_AW-1:2];
    assign unused_addr_bits = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0],
                                wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    assign rd_line = (rd_type == 3'b100);
    assign wr_line = (wr_type == 3'b100);

    // A pending or concurrent write blocks reads. This keeps read-after-write
    // ordering, and it means a simultaneous request pair always takes the write first.
    assign rd_rdy  = resetn & (rd_state == R_IDLE) & (wr_state == W_IDLE) & ~wr_req;
    assign wr_rdy  = resetn & (wr_state == W_IDLE);
    assign rd_fire = rd_req & rd_rdy;
    assign wr_fire = wr_req & wr_rdy;

    // The beat offset wraps inside the 16B line.
    assign beat_idx = {rd_base[MEM_AW-1:2], rd_base[1:0] + beat};

    always_comb begin
        rd_state_nxt = rd_state;
        lat_cnt_nxt  = lat_cnt;
        beat_nxt     = beat;
        rd_base_nxt  = rd_base;
        rd_last_nxt  = rd_last;
        ret_valid    = 1'b0;
        ret_last     = 2'b00;
        ret_data     = 32'd0;
        case (rd_state)
            R_IDLE: begin
                if (rd_fire) begin
                    rd_base_nxt  = rd_line ? {rd_idx[MEM_AW-1:2], 2'b00} : rd_idx;
                    rd_last_nxt  = rd_line ? 2'd3 : 2'd0;
                    beat_nxt     = 2'd0;
                    lat_cnt_nxt  = LAT_INIT;
                    rd_state_nxt = (RD_LAT <= 1) ? R_BEAT : R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    rd_state_nxt = R_BEAT;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            R_BEAT: begin
                // The RAM is sampled in the beat's own cycle, so a write that
                // lands mid-burst is seen by the beats that have not yet been returned.
                if (resetn) begin
                    ret_valid   = 1'b1;
                    ret_last[0] = (beat == rd_last);
                    ret_data    = mem[beat_idx];
                end
                if (beat == rd_last) begin
                    rd_state_nxt = R_IDLE;
                    beat_nxt     = 2'd0;
                end else begin
                    beat_nxt = beat + 2'd1;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_cnt_nxt   = wr_cnt;
        case (wr_state)
            W_IDLE: begin
                if (wr_fire && wr_line && (WR_LINE_CYC > 1)) begin
                    wr_state_nxt = W_BUSY;
                    wr_cnt_nxt   = WBUSY_INIT;
                end
            end
            W_BUSY: begin
                if (wr_cnt == 2'd0) begin
                    wr_state_nxt = W_IDLE;
                end else begin
                    wr_cnt_nxt = wr_cnt - 2'd1;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
            lat_cnt  <= 4'd0;
            beat     <= 2'd0;
            wr_state <= W_IDLE;
            wr_cnt   <= 2'd0;
        end else begin
            rd_state <= rd_state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            beat     <= beat_nxt;
            wr_state <= wr_state_nxt;
            wr_cnt   <= wr_cnt_nxt;
        end
    end

    // Burst descriptor. It is only meaningful once the handshake has loaded it.
    always_ff @(posedge clk) begin
        rd_base <= rd_base_nxt;
        rd_last <= rd_last_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (wr_line) begin
                mem[{wr_line_idx, 2'd0}] <= wr_data[31:0];
                mem[{wr_line_idx, 2'd1}] <= wr_data[63:32];
                mem[{wr_line_idx, 2'd2}] <= wr_data[95:64];
                mem[{wr_line_idx, 2'd3}] <= wr_data[127:96];
            end else begin
                if (wr_wstrb[0]) mem[wr_idx][7:0]   <= wr_data[7:0];
                if (wr_wstrb[1]) mem[wr_idx][15:8]  <= wr_data[15:8];
                if (wr_wstrb[2]) mem[wr_idx][23:16] <= wr_data[23:16];
                if (wr_wstrb[3]) mem[wr_idx][31:24] <= wr_data[31:24];
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder
//   Bench for cache_mem_responder. One instance uses the default latencies
//   (RD_LAT=2, WR_LINE_CYC=4). A second instance uses RD_LAT=1 and
//   WR_LINE_CYC=1 for the minimum-latency cases. Return beats of the first
//   instance are checked against a queue of expected {last, data} entries,
//   which is filled when each read is issued.
module tb_cache_mem_responder;

    logic         clk;
    logic         resetn, rd_req, rd_rdy, ret_valid, wr_req, wr_rdy;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, wr_addr, ret_data;
    logic [1:0]   ret_last;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;

    logic         b_resetn, b_rd_req, b_rd_rdy, b_ret_valid, b_wr_req, b_wr_rdy;
    logic [2:0]   b_rd_type, b_wr_type;
    logic [31:0]  b_rd_addr, b_wr_addr, b_ret_data;
    logic [1:0]   b_ret_last;
    logic [3:0]   b_wr_wstrb;
    logic [127:0] b_wr_data;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    typedef struct {
        logic [2:0]       wtype;
        logic [31:0]      waddr;
        logic [3:0]       wstrb;
        logic [127:0]     wdata;
        logic [2:0]       rtype;
        logic [31:0]      raddr;
        int               nb;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vecs[7];

    cache_mem_responder #(.MEM_AW(10), .RD_LAT(2), .WR_LINE_CYC(4)) u_dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    cache_mem_responder #(.MEM_AW(10), .RD_LAT(1), .WR_LINE_CYC(1)) u_lat1 (
        .clk(clk), .resetn(b_resetn),
        .rd_req(b_rd_req), .rd_type(b_rd_type), .rd_addr(b_rd_addr), .rd_rdy(b_rd_rdy),
        .ret_valid(b_ret_valid), .ret_last(b_ret_last), .ret_data(b_ret_data),
        .wr_req(b_wr_req), .wr_type(b_wr_type), .wr_addr(b_wr_addr),
        .wr_wstrb(b_wr_wstrb), .wr_data(b_wr_data), .wr_rdy(b_wr_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic fail_timeout(input string name);
        chk_cnt++;
        $display("FAIL %s: timed out, got no response, expected one", name);
    endtask

    // Beat scoreboard for the default instance.
    always @(negedge clk) begin
        if (ret_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL ret_unexpected: got beat %h, expected none", ret_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("ret_beat", {94'd0, ret_last, ret_data}, {94'd0, 1'b0, mon_e});
            end
        end
    end

    task automatic wait_rd_rdy();
        int n = 0;
        @(negedge clk);
        while (rd_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rd_rdy !== 1'b1) fail_timeout("wait_rd_rdy");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_timeout("drain_beats");
            exp_q.delete();
        end
    endtask

    task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                            input logic [3:0] s, input logic [127:0] d);
        int n = 0;
        @(negedge clk);
        while (wr_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (wr_rdy !== 1'b1) fail_timeout("wait_wr_rdy");
        wr_req   = 1'b1;
        wr_type  = t;
        wr_addr  = a;
        wr_wstrb = s;
        wr_data  = d;
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    // Issues one read and returns one time unit after the handshake edge.
    task automatic do_read(input logic [2:0] t, input logic [31:0] a,
                           input logic [3:0][31:0] e, input int nb);
        wait_rd_rdy();
        for (int i = 0; i < nb; i++) exp_q.push_back({(i == nb - 1), e[i]});
        rd_req  = 1'b1;
        rd_type = t;
        rd_addr = a;
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    initial begin
        logic [3:0][31:0] l40, l80, l100;
        l40  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        l80  = {32'h80000003, 32'h80000002, 32'h80000001, 32'h80000000};
        l100 = {32'hDDDD0003, 32'hCCCC0002, 32'h12345678, 32'hAAAA0000};

        vecs[0] = '{3'b000, 32'h44,    4'b0010, 128'h0000AB00, 3'b000, 32'h44,   1,
                    {96'd0, 32'h1111AB11}};
        vecs[1] = '{3'b010, 32'h48,    4'b0000, 128'hFFFFFFFF, 3'b001, 32'h48,   1,
                    {96'd0, 32'h22222222}};
        vecs[2] = '{3'b000, 32'h4C,    4'b1001, 128'hAABBCCDD, 3'b100, 32'h47,   4,
                    {32'hAA3333DD, 32'h22222222, 32'h1111AB11, 32'h00000000}};
        vecs[3] = '{3'b100, 32'h100,   4'b0000,
                    {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000},
                    3'b001, 32'h108, 1, {96'd0, 32'hCCCC0002}};
        vecs[4] = '{3'b011, 32'h1104,  4'b1111, 128'h12345678, 3'b100, 32'h10C,  4, l100};
        vecs[5] = '{3'b100, 32'hFF0,   4'b0000,
                    {32'h0F0F0003, 32'h0F0F0002, 32'h0F0F0001, 32'h0F0F0000},
                    3'b100, 32'hFFF8, 4,
                    {32'h0F0F0003, 32'h0F0F0002, 32'h0F0F0001, 32'h0F0F0000}};
        vecs[6] = '{3'b000, 32'h3FFFC, 4'b0100, 128'h00550000, 3'b111, 32'hFFC,  1,
                    {96'd0, 32'h0F550003}};

        // Reset with both requests held high.
        resetn = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        rd_type = 3'b100; rd_addr = 32'h40;
        wr_type = 3'b100; wr_addr = 32'h40; wr_wstrb = 4'hF; wr_data = '1;
        b_resetn = 1'b0; b_rd_req = 1'b0; b_wr_req = 1'b0;
        b_rd_type = 3'b000; b_rd_addr = 32'd0;
        b_wr_type = 3'b000; b_wr_addr = 32'd0; b_wr_wstrb = 4'h0; b_wr_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rd_rdy", rd_rdy, 1'b0);
            check("rst_wr_rdy", wr_rdy, 1'b0);
            check("rst_ret_valid", ret_valid, 1'b0);
            check("rst_ret_last", ret_last, 2'b00);
            check("rst_ret_data", ret_data, 32'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1; rd_req = 1'b0; wr_req = 1'b0; b_resetn = 1'b1;
        @(negedge clk);
        check("post_rst_rd_rdy", rd_rdy, 1'b1);
        check("post_rst_wr_rdy", wr_rdy, 1'b1);

        // Line write and a timed RD_LAT=2 line read.
        do_write(3'b100, 32'h40, 4'h0, l40);
        do_read(3'b100, 32'h40, l40, 4);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("lat2_rd_rdy_t%0d", k), rd_rdy, (k == 6));
            check($sformatf("lat2_valid_t%0d", k), ret_valid, (k >= 2 && k <= 5));
            check($sformatf("lat2_last_t%0d", k), ret_last[0], (k == 5));
        end
        wait_drain();

        // Vector table: a write followed by a read that observes it.
        for (int v = 0; v < 7; v++) begin
            do_write(vecs[v].wtype, vecs[v].waddr, vecs[v].wstrb, vecs[v].wdata);
            do_read(vecs[v].rtype, vecs[v].raddr, vecs[v].exp, vecs[v].nb);
            wait_drain();
        end

        // Simultaneous write and read requests to the same line.
        wait_rd_rdy();
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h80; wr_data = l80;
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h80;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), l80[i]});
        #1;
        check("sim_rd_rdy", rd_rdy, 1'b0);
        check("sim_wr_rdy", wr_rdy, 1'b1);
        @(posedge clk);
        #1 wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_rd_rdy", rd_rdy, 1'b0);
            check("busy_wr_rdy", wr_rdy, 1'b0);
        end
        @(negedge clk);
        check("after_busy_rd_rdy", rd_rdy, 1'b1);
        @(posedge clk);
        #1 rd_req = 1'b0;
        wait_drain();

        // Reset during the second beat of a line read.
        do_read(3'b100, 32'h100, l100, 4);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_valid", ret_valid, 1'b0);
            check("midrst_rd_rdy", rd_rdy, 1'b0);
        end
        check("midrst_beats_left", exp_q.size(), 3);
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_resume", ret_valid, 1'b0);
        end
        exp_q.delete();
        do_read(3'b100, 32'h100, l100, 4);
        wait_drain();

        // RD_LAT=1, WR_LINE_CYC=1 instance: back-to-back line reads.
        @(negedge clk);
        b_wr_req = 1'b1; b_wr_type = 3'b100; b_wr_addr = 32'h0;
        b_wr_data = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        @(posedge clk);
        #1 b_wr_addr = 32'h10;
        b_wr_data = {32'hB0000013, 32'hB0000012, 32'hB0000011, 32'hB0000010};
        @(negedge clk);
        check("lat1_wr_rdy_after_line", b_wr_rdy, 1'b1);
        @(posedge clk);
        #1 b_wr_req = 1'b0;
        @(negedge clk);
        check("lat1_rd_rdy_idle", b_rd_rdy, 1'b1);
        b_rd_req = 1'b1; b_rd_type = 3'b100; b_rd_addr = 32'h0;
        @(posedge clk);
        #1 b_rd_addr = 32'h10;
        for (int k = 1; k <= 11; k++) begin
            logic       ev;
            logic [31:0] ed;
            @(negedge clk);
            ev = (k >= 1 && k <= 4) || (k >= 6 && k <= 9);
            ed = (k <= 4) ? (32'hA0000000 + 32'(k - 1)) : (32'hB0000010 + 32'(k - 6));
            check($sformatf("lat1_valid_t%0d", k), b_ret_valid, ev);
            if (ev) begin
                check($sformatf("lat1_data_t%0d", k), b_ret_data, ed);
                check($sformatf("lat1_last_t%0d", k), b_ret_last, {1'b0, (k == 4 || k == 9)});
            end
            if (b_rd_req && b_rd_rdy && k > 1) begin
                @(posedge clk);
                #1 b_rd_req = 1'b0;
            end
        end
        b_rd_req = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
